// File: rtl/wb_master_if.sv
// wb_master_if: converts single-cycle CPU load/store requests into registered
// Wishbone-style bus cycles, stalls the pipeline until the bus acks, holds
// load data across external stalls and honours pipeline flush.
//
// Optional feature: define BUS_TIMEOUT_EN to enable an ack watchdog that
// abandons a bus cycle after TIMEOUT_CYCLES cycles without ack and pulses
// bus_err_o. Without the macro the master waits for ack indefinitely and
// bus_err_o is tied low.
module wb_master_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_select_o,
    output logic              bus_we_o,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] bus_addr_d;
    logic [DATA_W-1:0] bus_data_d;
    logic              bus_select_d;
    logic              bus_we_d;
    logic [DATA_W-1:0] rd_buf, rd_buf_d;
    logic              flushed, flushed_d;

    // A flush seen at any point of the current bus cycle (earlier or now)
    // means its result must be thrown away.
    logic              flush_now;
    logic [DATA_W-1:0] ack_data;
    logic              timeout;

    assign flush_now = flushed | flush_i;
    assign ack_data  = (!bus_we_o && !flush_now) ? bus_data_i : '0;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    assign timeout = (state == BUSY) && !bus_ack_i && (to_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Watchdog: counts BUSY cycles without ack, restarts whenever not busy.
    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            to_cnt <= '0;
        end else if (!bus_ack_i && !timeout) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign bus_err_o = timeout;

    // State register and registered bus outputs; reset drops any cycle in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state        <= IDLE;
            bus_addr_o   <= '0;
            bus_data_o   <= '0;
            bus_select_o <= 1'b0;
            bus_we_o     <= 1'b0;
            rd_buf       <= '0;
            flushed      <= 1'b0;
        end else begin
            state        <= state_d;
            bus_addr_o   <= bus_addr_d;
            bus_data_o   <= bus_data_d;
            bus_select_o <= bus_select_d;
            bus_we_o     <= bus_we_d;
            rd_buf       <= rd_buf_d;
            flushed      <= flushed_d;
        end
    end

    // Next-state logic plus the combinational CPU-side outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // left one unassigned would infer a latch.
        state_d      = state;
        bus_addr_d   = bus_addr_o;
        bus_data_d   = bus_data_o;
        bus_select_d = bus_select_o;
        bus_we_d     = bus_we_o;
        rd_buf_d     = rd_buf;
        flushed_d    = flushed;
        stallreq_o   = 1'b0;
        cpu_data_o   = '0;

        unique case (state)
            IDLE: begin
                stallreq_o = cpu_ce_i & ~flush_i;
                if (cpu_ce_i && !flush_i) begin
                    bus_addr_d   = cpu_addr_i;
                    bus_data_d   = cpu_data_i;
                    bus_we_d     = cpu_we_i;
                    bus_select_d = 1'b1;
                    flushed_d    = 1'b0;
                    state_d      = BUSY;
                end
            end

            BUSY: begin
                if (bus_ack_i) begin
                    // Ack wins over a simultaneous watchdog expiry.
                    cpu_data_o   = ack_data;
                    rd_buf_d     = ack_data;
                    bus_select_d = 1'b0;
                    bus_we_d     = 1'b0;
                    flushed_d    = 1'b0;
                    state_d      = (stall_i && !flush_now) ? WAIT_STALL : IDLE;
                end else if (timeout) begin
                    bus_select_d = 1'b0;
                    bus_we_d     = 1'b0;
                    rd_buf_d     = '0;
                    flushed_d    = 1'b0;
                    state_d      = (stall_i && !flush_now) ? WAIT_STALL : IDLE;
                end else begin
                    // The slave may be mid-write, so a flush only marks the
                    // cycle; it still runs to completion.
                    stallreq_o = 1'b1;
                    flushed_d  = flush_now;
                end
            end

            WAIT_STALL: begin
                cpu_data_o = rd_buf;
                if (flush_i) begin
                    rd_buf_d = '0;
                    state_d  = IDLE;
                end else if (!stall_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_if.sv
// tb_wb_master_if: scoreboard bench for wb_master_if. Each access pushes its
// expected bus fields and load result when the request is driven; the entry
// is checked while the bus cycle is open and popped on the ack cycle.
module tb_wb_master_if;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_select_o;
    logic        bus_we_o;
    logic        bus_ack_i;
    logic        bus_err_o;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_master_if #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_ce_i     (cpu_ce_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_data_i   (bus_data_i),
        .bus_select_o (bus_select_o),
        .bus_we_o     (bus_we_o),
        .bus_ack_i    (bus_ack_i),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string ph);
        check({ph, "_select"}, bus_select_o, 1);
        check({ph, "_we"}, bus_we_o, exp_q[0].we);
        check({ph, "_addr"}, bus_addr_o, exp_q[0].addr);
        check({ph, "_wdata"}, bus_data_o, exp_q[0].wdata);
    endtask

    // One CPU access: request cycle, 'waits' BUSY cycles without ack, ack
    // cycle, then either an external stall of 'stall_cycles' extra cycles or
    // straight back to idle. flush_at >= 0 pulses flush_i in that wait cycle.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits, input int stall_cycles,
                              input int flush_at);
        txn_t t;
        bit   fl;
        fl      = (flush_at >= 0);
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.rdata = (we || fl) ? 32'h0 : rdata;
        exp_q.push_back(t);

        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_data_i = wdata;
        @(negedge clk);
        check("req_stallreq", stallreq_o, 1);
        check("req_cpu_data", cpu_data_o, 0);
        tick();
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'($urandom);
        cpu_addr_i = $urandom;
        cpu_data_i = $urandom;

        for (int w = 0; w < waits; w++) begin
            flush_i = (w == flush_at);
            @(negedge clk);
            check_bus("wait");
            check("wait_stallreq", stallreq_o, 1);
            check("wait_cpu_data", cpu_data_o, 0);
            tick();
        end

        flush_i    = 1'b0;
        bus_ack_i  = 1'b1;
        bus_data_i = rdata;
        stall_i    = (stall_cycles > 0);
        @(negedge clk);
        check_bus("ack");
        t = exp_q.pop_front();
        check("ack_stallreq", stallreq_o, 0);
        check("ack_cpu_data", cpu_data_o, t.rdata);
        check("ack_err", bus_err_o, 0);
        tick();
        bus_ack_i  = 1'b0;
        bus_data_i = $urandom;

        if (fl) begin
            // stall_i is left high: the next request must still be accepted.
            @(negedge clk);
            check("flush_select", bus_select_o, 0);
            check("flush_cpu_data", cpu_data_o, 0);
            check("flush_stallreq", stallreq_o, 0);
            tick();
        end else if (stall_cycles > 0) begin
            for (int s = 0; s < stall_cycles; s++) begin
                @(negedge clk);
                check("hold_cpu_data", cpu_data_o, t.rdata);
                check("hold_stallreq", stallreq_o, 0);
                check("hold_select", bus_select_o, 0);
                tick();
            end
            stall_i = 1'b0;
            @(negedge clk);
            check("release_cpu_data", cpu_data_o, t.rdata);
            tick();
            @(negedge clk);
            check("after_hold_cpu_data", cpu_data_o, 0);
            check("after_hold_select", bus_select_o, 0);
            tick();
        end else begin
            @(negedge clk);
            check("idle_select", bus_select_o, 0);
            check("idle_we", bus_we_o, 0);
            check("idle_cpu_data", cpu_data_o, 0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, required end before 100000");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        bus_data_i = '0;
        bus_ack_i  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_select", bus_select_o, 0);
        check("rst_we", bus_we_o, 0);
        check("rst_addr", bus_addr_o, 0);
        check("rst_wdata", bus_data_o, 0);
        check("rst_stallreq", stallreq_o, 0);
        check("rst_cpu_data", cpu_data_o, 0);
        check("rst_err", bus_err_o, 0);
        tick();
        rst = 1'b0;

        // Minimum-latency load, store with 3 wait states, load held by stall.
        run_access(1'b0, 32'h0000_0040, $urandom, 32'h1234_5678, 0, 0, -1);
        run_access(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, $urandom, 3, 0, -1);
        run_access(1'b0, 32'h0000_0100, $urandom, 32'hA5A5_A5A5, 0, 2, -1);

        // Flush in the second BUSY cycle, ack two cycles later under stall;
        // the following access proves the master went back to IDLE.
        run_access(1'b0, 32'h0000_0200, $urandom, 32'h1111_1111, 3, 1, 1);
        run_access(1'b0, 32'h0000_0300, $urandom, 32'h0BAD_F00D, 1, 0, -1);

        // Flush together with a request in IDLE starts no bus cycle.
        cpu_ce_i   = 1'b1;
        flush_i    = 1'b1;
        cpu_addr_i = 32'h0000_0500;
        @(negedge clk);
        check("idle_flush_stallreq", stallreq_o, 0);
        tick();
        cpu_ce_i = 1'b0;
        flush_i  = 1'b0;
        @(negedge clk);
        check("idle_flush_select", bus_select_o, 0);
        check("idle_flush_addr", bus_addr_o, 32'h0000_0300);
        tick();

        // Reset while BUSY drops the cycle; a late ack is ignored.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b1;
        cpu_addr_i = 32'h0000_0400;
        cpu_data_i = 32'hCAFE_F00D;
        tick();
        cpu_ce_i = 1'b0;
        @(negedge clk);
        check("rst_busy_select", bus_select_o, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_select_drop", bus_select_o, 0);
        check("rst_busy_we", bus_we_o, 0);
        check("rst_busy_addr", bus_addr_o, 0);
        check("rst_busy_wdata", bus_data_o, 0);
        check("rst_busy_stallreq", stallreq_o, 0);
        check("rst_busy_cpu_data", cpu_data_o, 0);
        tick();
        bus_ack_i  = 1'b1;
        bus_data_i = 32'h7777_7777;
        stall_i    = 1'b1;
        @(negedge clk);
        check("stray_ack_cpu_data", cpu_data_o, 0);
        check("stray_ack_stallreq", stallreq_o, 0);
        tick();
        bus_ack_i = 1'b0;
        @(negedge clk);
        check("stray_ack_after_cpu_data", cpu_data_o, 0);
        check("stray_ack_after_select", bus_select_o, 0);
        tick();
        stall_i = 1'b0;

`ifdef BUS_TIMEOUT_EN
        // No ack: watchdog fires 4 cycles after bus_select_o rises.
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0600;
        tick();
        cpu_ce_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("to_wait_stallreq", stallreq_o, 1);
            check("to_wait_err", bus_err_o, 0);
            tick();
        end
        @(negedge clk);
        check("to_err", bus_err_o, 1);
        check("to_stallreq", stallreq_o, 0);
        check("to_cpu_data", cpu_data_o, 0);
        tick();
        @(negedge clk);
        check("to_err_clear", bus_err_o, 0);
        check("to_select", bus_select_o, 0);
        tick();
`else
        @(negedge clk);
        check("no_timeout_err", bus_err_o, 0);
        tick();
`endif

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_master_if.md
Name: wb_master_if

Overview:
- Upstream neighbour of the data-RAM bus slave; sits between the CPU memory stage and the Wishbone-style data bus.
- Converts single-cycle CPU load/store requests into registered bus cycles (address, data, select, write-enable) and waits for bus ack.
- Stalls the pipeline until the access completes and holds read data across external pipeline stalls.
- Honours pipeline flush: no new cycle is started, and the result of a flushed cycle is discarded.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus/CPU data width
- TIMEOUT_CYCLES, 255, ack watchdog limit; used only with BUS_TIMEOUT_EN

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_ce_i  in  1  CPU access request
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  access address
- cpu_data_i  in  DATA_W  store data
- cpu_data_o  out  DATA_W  load data to CPU
- stall_i  in  1  pipeline stalled by another source
- flush_i  in  1  pipeline flush
- stallreq_o  out  1  stall request to pipeline control
- bus_addr_o  out  ADDR_W  bus address, registered
- bus_data_o  out  DATA_W  bus write data, registered
- bus_data_i  in  DATA_W  bus read data
- bus_select_o  out  1  bus cycle strobe, registered
- bus_we_o  out  1  bus write enable, registered
- bus_ack_i  in  1  bus completion
- bus_err_o  out  1  one-cycle timeout pulse; constant 0 without BUS_TIMEOUT_EN

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - state = IDLE.
  - bus_select_o, bus_we_o, bus_addr_o, bus_data_o = 0.
  - Read buffer rd_buf = 0.
  - bus_err_o = 0.
  - Reset mid-cycle drops bus_select_o on the next edge and discards the access.
- FSM states: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - When cpu_ce_i=1 and flush_i=0: register bus_addr_o=cpu_addr_i, bus_data_o=cpu_data_i, bus_we_o=cpu_we_i, bus_select_o=1; go to BUSY.
  - Combinational outputs: stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
- BUSY:
  - Bus outputs held stable.
  - When bus_ack_i=0: stallreq_o=1, cpu_data_o=0.
  - When bus_ack_i=1:
    - Combinational: stallreq_o=0; cpu_data_o = bus_data_i for a load, 0 for a store.
    - Registered: bus_select_o=0, bus_we_o=0; rd_buf captures bus_data_i for a load, 0 for a store.
    - Next state: WAIT_STALL if stall_i=1, else IDLE.
- Flush in BUSY:
  - Sets a sticky `flushed` flag; the bus cycle is not aborted (the slave may be mid-write).
  - On ack: rd_buf=0, cpu_data_o=0, next state IDLE regardless of stall_i; flag clears.
- WAIT_STALL:
  - stallreq_o=0; cpu_data_o=rd_buf.
  - Go to IDLE when stall_i=0.
  - flush_i=1 goes to IDLE immediately and clears rd_buf.
- Latency:
  - Request sampled at edge N; bus_select_o is high from N+1.
  - Earliest ack is in cycle N+1, giving a 2-cycle minimum access with stallreq_o high for exactly 1 cycle.
- Back-to-back requests: a new request is accepted only from IDLE, so there is at least one idle bus cycle between accesses.
- Ack while not in BUSY: ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES without ack: bus_select_o=0, bus_err_o pulses 1 for one cycle, rd_buf=0, cpu_data_o=0, stallreq_o=0 in that cycle; next state is IDLE (WAIT_STALL if stall_i=1).
  - An ack in the same cycle as the timeout takes priority; no error.
- Disabled: no counter; BUSY waits indefinitely; bus_err_o tied 0.

Test Plan:
- Load, ack one cycle after select: addr 0x00000040, bus_data_i=0x12345678 -> bus_select_o high 1 cycle, bus_we_o=0, stallreq_o high 1 cycle, cpu_data_o=0x12345678 in the ack cycle.
- Store with 3 wait cycles: addr 0x80, data 0xDEADBEEF -> bus_we_o=1, bus_data_o=0xDEADBEEF held 4 cycles, stallreq_o high 4 cycles, drops in the ack cycle.
- Load acked while stall_i=1 for 2 more cycles: data 0xA5A5A5A5 -> state WAIT_STALL, cpu_data_o=0xA5A5A5A5 through the stall, stallreq_o=0, then IDLE.
- flush_i in the second BUSY cycle, ack 2 cycles later with 0x11111111 -> bus cycle completes, cpu_data_o=0, no WAIT_STALL even with stall_i=1; flush_i with cpu_ce_i in IDLE -> no bus_select_o.
- rst asserted in BUSY -> next edge: bus_select_o=0, all outputs 0, state IDLE; a later ack is ignored.
- BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_err_o pulses once 4 cycles after select, stallreq_o released, cpu_data_o=0.
